// File: rtl/dial_emu.sv
// Rotary dial (quadrature spinner) emulator: turns per-channel inc/dec requests into Gray-coded
// phase steps at a programmable rate with optional acceleration, or passes joystick levels through.
module dial_emu #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned ACC_STEPS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [CHANNELS-1:0]   enable,
    input  logic [CHANNELS-1:0]   invert,
    input  logic [CHANNELS-1:0]   inc,
    input  logic [CHANNELS-1:0]   dec,
    input  logic [DIV_W-1:0]      rate,
    input  logic                  accel_en,
    output logic [2*CHANNELS-1:0] dial,
    output logic [8*CHANNELS-1:0] pos,
    output logic [CHANNELS-1:0]   step
);

    localparam int unsigned HOLD_W = ($clog2(ACC_STEPS + 1) > 0) ? $clog2(ACC_STEPS + 1) : 1;

    function automatic logic [1:0] gray(input logic [1:0] idx);
        return {idx[1], idx[1] ^ idx[0]};
    endfunction

    // Shared terminal counts (interval - 1), with a zero interval treated as one tick.
    logic [DIV_W-1:0] rate_half;
    logic [DIV_W-1:0] lim_base;
    logic [DIV_W-1:0] lim_fast;

    always_comb begin
        rate_half = rate >> 1;
        lim_base  = (rate == '0) ? '0 : DIV_W'(rate - DIV_W'(1));
        lim_fast  = (rate_half == '0) ? '0 : DIV_W'(rate_half - DIV_W'(1));
    end

    for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : g_ch
        logic             up, dn, fwd, rev;
        logic [1:0]       phase_q, phase_d;
        logic [7:0]       pos_q, pos_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [1:0]       last_q, last_d;
        logic [1:0]       dial_q, dial_d;
        logic             step_q, step_d;
        logic             do_step;
        logic [DIV_W-1:0] lim;

        always_comb begin
            up  = invert[ch] ? dec[ch] : inc[ch];
            dn  = invert[ch] ? inc[ch] : dec[ch];
            fwd = up & ~dn;
            rev = dn & ~up;
            lim = (accel_en && hold_q >= HOLD_W'(ACC_STEPS)) ? lim_fast : lim_base;
        end

        // Next-state: divider/hold bookkeeping and phase stepping, only on ce ticks.
        always_comb begin
            phase_d = phase_q;
            pos_d   = pos_q;
            div_d   = div_q;
            hold_d  = hold_q;
            last_d  = last_q;
            dial_d  = gray(phase_q);
            step_d  = 1'b0;
            do_step = 1'b0;
            if (!enable[ch]) begin
                dial_d = {dn, up};
                div_d  = '0;
                hold_d = '0;
                last_d = 2'b00;
            end else if (ce) begin
                if (!(fwd | rev)) begin
                    div_d  = '0;
                    hold_d = '0;
                    last_d = 2'b00;
                end else if ({rev, fwd} != last_q) begin
                    // Start from idle or a reversal: step now, count this as the first held step.
                    do_step = 1'b1;
                    div_d   = '0;
                    hold_d  = HOLD_W'(1);
                    last_d  = {rev, fwd};
                end else if (div_q >= lim) begin
                    do_step = 1'b1;
                    div_d   = '0;
                    hold_d  = (hold_q >= HOLD_W'(ACC_STEPS)) ? hold_q : HOLD_W'(hold_q + HOLD_W'(1));
                end else begin
                    div_d = DIV_W'(div_q + DIV_W'(1));
                end
                if (do_step) begin
                    phase_d = fwd ? 2'(phase_q + 2'd1) : 2'(phase_q - 2'd1);
                    pos_d   = fwd ? 8'(pos_q + 8'd1) : 8'(pos_q - 8'd1);
                    step_d  = 1'b1;
                end
                dial_d = gray(phase_d);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase_q <= 2'b00;
                pos_q   <= 8'h00;
                div_q   <= '0;
                hold_q  <= '0;
                last_q  <= 2'b00;
                dial_q  <= 2'b00;
                step_q  <= 1'b0;
            end else begin
                phase_q <= phase_d;
                pos_q   <= pos_d;
                div_q   <= div_d;
                hold_q  <= hold_d;
                last_q  <= last_d;
                dial_q  <= dial_d;
                step_q  <= step_d;
            end
        end

        assign dial[2*ch +: 2] = dial_q;
        assign pos[8*ch +: 8]  = pos_q;
        assign step[ch]        = step_q;
    end

endmodule

// File: tb/tb_dial_emu.sv
// Self-checking bench for dial_emu: directed scenarios plus randomized traffic against a behavioural model.
module tb_dial_emu;

    localparam int CH  = 2;
    localparam int DW  = 16;
    localparam int ACC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic          accel_en;
    logic [CH-1:0] enable, invert, inc, dec;
    logic [DW-1:0] rate;
    logic [2*CH-1:0] dial;
    logic [8*CH-1:0] pos;
    logic [CH-1:0]   step;

    int errors = 0;
    int checks = 0;

    dial_emu #(.CHANNELS(CH), .DIV_W(DW), .ACC_STEPS(ACC)) dut (
        .clk(clk), .reset(reset), .ce(ce), .enable(enable), .invert(invert),
        .inc(inc), .dec(dec), .rate(rate), .accel_en(accel_en),
        .dial(dial), .pos(pos), .step(step)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase index, position, ce ticks since last step, held-step count, last direction.
    logic [1:0] gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int m_ph [CH], m_pos [CH], m_cnt [CH], m_hold [CH], m_last [CH];
    logic [1:0] m_dial [CH];
    bit m_step [CH];
    logic [2*CH-1:0] e_dial;
    logic [8*CH-1:0] e_pos;
    logic [CH-1:0]   e_step;

    task automatic model_pack();
        for (int c = 0; c < CH; c++) begin
            e_dial[2*c +: 2] = m_dial[c];
            e_pos[8*c +: 8]  = 8'(m_pos[c]);
            e_step[c]        = m_step[c];
        end
    endtask

    task automatic model_zero();
        for (int c = 0; c < CH; c++) begin
            m_ph[c] = 0; m_pos[c] = 0; m_cnt[c] = 0; m_hold[c] = 0; m_last[c] = 0;
            m_dial[c] = 2'b00; m_step[c] = 0;
        end
        model_pack();
    endtask

    task automatic model_edge();
        if (reset) begin
            model_zero();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            bit u, d, go;
            int dv, ivl;
            u  = invert[c] ? dec[c] : inc[c];
            d  = invert[c] ? inc[c] : dec[c];
            dv = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
            go = 0;
            m_step[c] = 0;
            if (!enable[c]) begin
                m_dial[c] = {d, u};
                m_cnt[c] = 0; m_hold[c] = 0; m_last[c] = 0;
            end else begin
                if (ce) begin
                    if (dv == 0) begin
                        m_cnt[c] = 0; m_hold[c] = 0; m_last[c] = 0;
                    end else if (dv != m_last[c]) begin
                        go = 1; m_cnt[c] = 0; m_hold[c] = 1; m_last[c] = dv;
                    end else begin
                        ivl = (rate == 0) ? 1 : int'(rate);
                        if (accel_en && m_hold[c] >= ACC) ivl = (rate / 2 == 0) ? 1 : int'(rate / 2);
                        if (m_cnt[c] + 1 >= ivl) begin
                            go = 1; m_cnt[c] = 0;
                            m_hold[c] = (m_hold[c] + 1 > ACC) ? ACC : m_hold[c] + 1;
                        end else begin
                            m_cnt[c]++;
                        end
                    end
                    if (go) begin
                        m_ph[c]   = (m_ph[c] + dv + 4) % 4;
                        m_pos[c]  = (m_pos[c] + dv + 256) % 256;
                        m_step[c] = 1;
                    end
                end
                m_dial[c] = gray_tbl[m_ph[c]];
            end
        end
        model_pack();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        enable = '1; invert = '0; inc = '0; dec = '0;
        ce = 1'b1; accel_en = 1'b0; rate = 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_zero();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        model_zero();
        #1;
        checks++;
        if (dial !== e_dial || pos !== e_pos || step !== e_step) begin
            errors++;
            $display("FAIL reset_async: dial=%h pos=%h step=%b expected dial=%h pos=%h step=%b", dial, pos, step, e_dial, e_pos, e_step);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (dial !== 4'h0 || pos !== 16'h0 || step !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: dial=%h pos=%h step=%b expected all zero", dial, pos, step);
        end
    endtask

    task automatic test_rate3();
        set_idle();
        rate = 16'd3;
        inc[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (dial !== e_dial || pos !== e_pos || step !== e_step) begin
                errors++;
                $display("FAIL rate3_model k=%0d: dial=%h pos=%h step=%b expected dial=%h pos=%h step=%b", k, dial, pos, step, e_dial, e_pos, e_step);
            end
            checks++;
            if (step[0] !== (k == 1 || k == 4 || k == 7)) begin
                errors++;
                $display("FAIL rate3_step k=%0d: step0=%b expected %b", k, step[0], (k == 1 || k == 4 || k == 7));
            end
        end
        checks++;
        if (dial[1:0] !== 2'b10 || pos[7:0] !== 8'd3) begin
            errors++;
            $display("FAIL rate3_final: dial0=%b pos0=%h expected dial0=10 pos0=03", dial[1:0], pos[7:0]);
        end
        inc[0] = 1'b0;
        tick();
    endtask

    task automatic test_dec_wrap();
        set_idle();
        do_reset();
        dec[0] = 1'b1;
        tick();
        checks++;
        if (dial[1:0] !== 2'b10 || pos[7:0] !== 8'hFF || step[0] !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap1: dial0=%b pos0=%h step0=%b expected 10 ff 1", dial[1:0], pos[7:0], step[0]);
        end
        tick();
        checks++;
        if (dial[1:0] !== 2'b11 || pos[7:0] !== 8'hFE || step[0] !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap2: dial0=%b pos0=%h step0=%b expected 11 fe 1", dial[1:0], pos[7:0], step[0]);
        end
        dec[0] = 1'b0;
        tick();
        checks++;
        if (step[0] !== 1'b0 || pos[7:0] !== 8'hFE) begin
            errors++;
            $display("FAIL dec_release: step0=%b pos0=%h expected 0 fe", step[0], pos[7:0]);
        end
    endtask

    task automatic test_accel();
        int sc [$];
        set_idle();
        accel_en = 1'b1;
        rate = 16'd4;
        inc[0] = 1'b1;
        for (int k = 0; k < 44; k++) begin
            tick();
            if (step[0]) sc.push_back(k);
            checks++;
            if (dial !== e_dial || pos !== e_pos || step !== e_step) begin
                errors++;
                $display("FAIL accel_model k=%0d: dial=%h pos=%h step=%b expected dial=%h pos=%h step=%b", k, dial, pos, step, e_dial, e_pos, e_step);
            end
        end
        checks++;
        if (sc.size() < 12) begin
            errors++;
            $display("FAIL accel_count: steps=%0d expected at least 12", sc.size());
        end else begin
            for (int i = 1; i < 12; i++) begin
                checks++;
                if (sc[i] - sc[i-1] != ((i < 8) ? 4 : 2)) begin
                    errors++;
                    $display("FAIL accel_gap i=%0d: gap=%0d expected %0d", i, sc[i] - sc[i-1], (i < 8) ? 4 : 2);
                end
            end
        end
        inc[0] = 1'b0;
        tick();
        inc[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (step[0] !== (k == 1 || k == 5)) begin
                errors++;
                $display("FAIL accel_cleared k=%0d: step0=%b expected %b", k, step[0], (k == 1 || k == 5));
            end
        end
        inc[0] = 1'b0;
        accel_en = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        logic [1:0] code;
        logic [7:0] p0;
        set_idle();
        tick();
        code = dial[1:0];
        p0 = pos[7:0];
        enable[0] = 1'b0; invert[0] = 1'b1; inc[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dial[1:0] !== 2'b10 || step[0] !== 1'b0 || pos[7:0] !== p0) begin
                errors++;
                $display("FAIL passthru: dial0=%b step0=%b pos0=%h expected 10 0 %h", dial[1:0], step[0], pos[7:0], p0);
            end
        end
        enable[0] = 1'b1; invert[0] = 1'b0; inc[0] = 1'b0;
        tick();
        checks++;
        if (dial[1:0] !== code || pos[7:0] !== p0 || dial !== e_dial) begin
            errors++;
            $display("FAIL passthru_exit: dial0=%b pos0=%h expected %b %h", dial[1:0], pos[7:0], code, p0);
        end
    endtask

    task automatic test_both_reverse();
        logic [7:0] p0;
        set_idle();
        tick();
        p0 = pos[7:0];
        inc[0] = 1'b1; dec[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (step[0] !== 1'b0 || pos[7:0] !== p0) begin
                errors++;
                $display("FAIL both_pressed: step0=%b pos0=%h expected 0 %h", step[0], pos[7:0], p0);
            end
        end
        rate = 16'd4;
        dec[0] = 1'b0;
        tick(); tick(); tick();
        inc[0] = 1'b0; dec[0] = 1'b1;
        tick();
        checks++;
        if (step[0] !== 1'b1 || pos[7:0] !== p0 || dial !== e_dial) begin
            errors++;
            $display("FAIL reversal: step0=%b pos0=%h dial=%h expected 1 %h %h", step[0], pos[7:0], dial, p0, e_dial);
        end
        dec[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_idle();
        rate = 16'd5;
        inc[0] = 1'b1;
        tick(); tick(); tick(); tick();
        #2 reset = 1'b1;
        model_zero();
        #1;
        checks++;
        if (dial !== 4'h0 || pos !== 16'h0 || step !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: dial=%h pos=%h step=%b expected all zero", dial, pos, step);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (step[0] !== 1'b1 || pos[7:0] !== 8'd1 || dial[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL reset_restart: step0=%b pos0=%h dial0=%b expected 1 01 01", step[0], pos[7:0], dial[1:0]);
        end
        inc[0] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        set_idle();
        for (int k = 0; k < 3000; k++) begin
            ce = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 40) == 0) rate = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 200) == 0) accel_en = ~accel_en;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 12) == 0) inc[c] = ~inc[c];
                if ($urandom_range(0, 15) == 0) dec[c] = ~dec[c];
                if ($urandom_range(0, 60) == 0) enable[c] = ~enable[c];
                if ($urandom_range(0, 150) == 0) invert[c] = ~invert[c];
            end
            reset = ($urandom_range(0, 500) == 0);
            tick();
            checks++;
            if (dial !== e_dial || pos !== e_pos || step !== e_step) begin
                errors++;
                $display("FAIL random k=%0d: dial=%h pos=%h step=%b expected dial=%h pos=%h step=%b", k, dial, pos, step, e_dial, e_pos, e_step);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        set_idle();
        model_zero();
        test_reset();
        test_rate3();
        test_dec_wrap();
        test_accel();
        test_passthrough();
        test_both_reverse();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dial_emu.md
DIAL_EMU -- requirements
Module: dial_emu

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent dial channels.
REQ-002 SHALL have parameter DIV_W, default 16, width of the step-interval divider.
REQ-003 SHALL have parameter ACC_STEPS, default 8: consecutive same-direction steps before acceleration.
REQ-004 clk  in  1  system clock; all state advances on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 ce  in  1  step-timebase tick; the divider counts only on cycles with ce=1.
REQ-007 enable  in  CHANNELS  per-channel mode: 1=spinner emulation, 0=joystick passthrough.
REQ-008 invert  in  CHANNELS  per-channel direction swap (inc/dec exchanged before all other use).
REQ-009 inc  in  CHANNELS  per-channel clockwise request (active-high, level).
REQ-010 dec  in  CHANNELS  per-channel counter-clockwise request (active-high, level).
REQ-011 rate  in  DIV_W  step interval in ce ticks, shared by all channels; 0 treated as 1.
REQ-012 accel_en  in  1  enables interval halving after ACC_STEPS steps.
REQ-013 dial  out  2*CHANNELS  registered 2-bit phase per channel, channel n at [2n+1:2n].
REQ-014 pos  out  8*CHANNELS  registered 8-bit position per channel, channel n at [8n+7:8n].
REQ-015 step  out  CHANNELS  one-clk pulse per channel on every phase step.

Function
REQ-016 Per channel, after invert: dir=+1 if inc&~dec, dir=-1 if dec&~inc, idle if both or neither.
REQ-017 Spinner mode SHALL walk phase index 0..3 mapped to Gray codes 00,01,11,10 on dial.
REQ-018 A +1 step SHALL increment index mod 4 and pos mod 256; a -1 step SHALL decrement both with wrap (0->3, 0x00->0xFF).
REQ-019 Idle->active transition SHALL step on the first ce=1 cycle with dir active, then once every interval ce ticks while dir is unchanged.
REQ-020 Interval SHALL be max(rate,1); with accel_en=1 and hold count >= ACC_STEPS, interval SHALL be max(rate>>1,1).
REQ-021 Hold count SHALL saturate at ACC_STEPS, increment per step, clear on idle, reversal, or enable=0.
REQ-022 Direction reversal (+1 to -1 directly) SHALL be treated as a fresh start: divider cleared, step on next ce tick.
REQ-023 While idle, divider SHALL be held at 0; phase and pos SHALL hold.
REQ-024 Step outputs (dial, pos, step) SHALL update on the clk edge that samples the qualifying ce; latency 1 clk from ce.
REQ-025 ce=0 cycles SHALL neither count nor step; dir changes on ce=0 cycles take effect at the next ce=1.
REQ-026 Passthrough mode (enable=0) SHALL drive dial[2n+1:2n]={dec,inc} after invert, registered, step=0, pos and phase frozen, divider and hold cleared.
REQ-027 Leaving passthrough SHALL restore dial to the Gray code of the frozen phase on the next clk.
REQ-028 A mid-run rate change SHALL apply at the next interval comparison without resetting the divider; divider >= new interval-1 forces a step on the next ce.
REQ-029 Channels SHALL be fully independent except for shared ce, rate, accel_en.

Reset
REQ-030 On reset: dial=0 (phase 0), pos=0, step=0, dividers and hold counts 0, in every channel, regardless of ce.
REQ-031 Reset asserted mid-interval SHALL abandon the pending step; after release, the first ce with dir active steps immediately.

Verification
REQ-032 CH0 enable=1, rate=3, ce every clk, inc held 7 clks -> steps at ce 1,4,7; dial 01,11,10; pos 1,2,3.
REQ-033 pos=0, dec held, rate=1 -> dial 10 then 11, pos 0xFF then 0xFE; step pulses 1 clk each.
REQ-034 accel_en=1, rate=4, inc held -> first 8 steps spaced 4 ce ticks, subsequent spaced 2; release clears hold.
REQ-035 enable=0, invert=1, inc=1 -> dial={1,0}, step=0, pos unchanged; re-enable -> dial equals frozen phase code.
REQ-036 inc and dec both 1 -> no steps; inc held, switch to dec mid-interval -> -1 step on next ce.
REQ-037 Reset asserted while rate=5 divider at 3 -> all outputs 0 asynchronously; post-release inc steps on first ce.
